ccip_c1tx_pkt_checker: RTL and testbench

Protocol checker that sits directly upstream of the CCI-P sniffer's warning logger and tracks C1Tx write packets beat by beat. It enforces multi-cacheline write framing (SOP, length, address alignment, beat sequence) and almost-full slack. It emits one registered error event per cycle, with a code, address and saturating count. The sniffer consumes these events for logging and sim-kill decisions.

---
 rtl/ccip_c1tx_pkt_checker.sv | 177 +++++++++++++++++
 tb/tb_ccip_c1tx_pkt_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c1tx_pkt_checker.sv
// CCI-P C1Tx write-packet protocol checker: tracks multi-cacheline write framing and
// almost-full slack, and reports one registered error event per cycle.
module ccip_c1tx_pkt_checker #(
    parameter int ADDR_WIDTH    = 42,
    parameter int ERRCNT_WIDTH  = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic                    clk,
    input  logic                    SoftReset_n,
    input  logic                    C1TxWrValid,
    input  logic                    C1TxSop,
    input  logic [1:0]              C1TxLen,
    input  logic [1:0]              C1TxVc,
    input  logic [ADDR_WIDTH-1:0]   C1TxAddr,
    input  logic                    C1TxAlmFull,
    output logic                    err_valid,
    output logic [2:0]              err_code,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic [7:0]              err_mask,
    output logic [ERRCNT_WIDTH-1:0] err_count,
    output logic                    pkt_done,
    output logic                    in_pkt
);

    localparam logic [2:0] CODE_SOP_MISSING    = 3'd1;
    localparam logic [2:0] CODE_SOP_UNEXPECTED = 3'd2;
    localparam logic [2:0] CODE_LEN_ILLEGAL    = 3'd3;
    localparam logic [2:0] CODE_ADDR_MISALIGN  = 3'd4;
    localparam logic [2:0] CODE_BEAT_MISMATCH  = 3'd5;
    localparam logic [2:0] CODE_ALMFULL_OVR    = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_base_addr;
    logic [1:0]              r_pkt_len;
    logic [1:0]              r_pkt_vc;
    logic [1:0]              r_beat_idx;
    logic [1:0]              r_beats_left;
    logic [3:0]              r_slack_cnt;
    logic                    r_err_valid;
    logic [2:0]              r_err_code;
    logic [ADDR_WIDTH-1:0]   r_err_addr;
    logic [7:0]              r_err_mask;
    logic [ERRCNT_WIDTH-1:0] r_err_count;
    logic                    r_pkt_done;

    state_t                  w_state_nxt;
    logic [7:0]              w_fired;
    logic                    w_done;
    logic                    w_open;
    logic                    w_advance;
    logic                    w_mismatch;
    logic [3:0]              w_slack_nxt;
    logic [ADDR_WIDTH-1:0]   w_exp_addr;

    function automatic logic [3:0] slack_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    function automatic logic [ERRCNT_WIDTH-1:0] errcnt_inc(input logic [ERRCNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
        return ((len == 2'd1) && (addr_lo[0] != 1'b0)) ||
               ((len == 2'd3) && (addr_lo != 2'd0));
    endfunction

    // Overrun outranks every framing code; otherwise the lowest framing code wins.
    function automatic logic [2:0] pick_code(input logic [7:0] fired);
        if (fired[6])      return CODE_ALMFULL_OVR;
        else if (fired[1]) return CODE_SOP_MISSING;
        else if (fired[2]) return CODE_SOP_UNEXPECTED;
        else if (fired[3]) return CODE_LEN_ILLEGAL;
        else if (fired[4]) return CODE_ADDR_MISALIGN;
        else               return CODE_BEAT_MISMATCH;
    endfunction

    assign w_exp_addr = r_base_addr | {{(ADDR_WIDTH-2){1'b0}}, r_beat_idx};
    assign w_mismatch = (C1TxLen != r_pkt_len) || (C1TxVc != r_pkt_vc) ||
                        (C1TxAddr != w_exp_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_fired     = 8'd0;
        w_done      = 1'b0;
        w_open      = 1'b0;
        w_advance   = 1'b0;
        if (C1TxWrValid) begin
            if ((r_state == ST_PKT) && C1TxSop)
                w_fired[CODE_SOP_UNEXPECTED] = 1'b1;
            if ((r_state == ST_IDLE) || C1TxSop) begin
                w_state_nxt = ST_IDLE;
                if (!C1TxSop)
                    w_fired[CODE_SOP_MISSING] = 1'b1;
                else if (C1TxLen == 2'd2)
                    w_fired[CODE_LEN_ILLEGAL] = 1'b1;
                else if (is_misaligned(C1TxLen, C1TxAddr[1:0]))
                    w_fired[CODE_ADDR_MISALIGN] = 1'b1;
                else if (C1TxLen == 2'd0)
                    w_done = 1'b1;
                else begin
                    w_open      = 1'b1;
                    w_state_nxt = ST_PKT;
                end
            end else if (w_mismatch) begin
                w_fired[CODE_BEAT_MISMATCH] = 1'b1;
                w_state_nxt                 = ST_IDLE;
            end else begin
                w_advance = 1'b1;
                if (r_beats_left == 2'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        end
        if (!C1TxAlmFull)
            w_slack_nxt = 4'd0;
        else if (C1TxWrValid)
            w_slack_nxt = slack_inc(r_slack_cnt);
        else
            w_slack_nxt = r_slack_cnt;
        if (C1TxAlmFull && C1TxWrValid && (int'(w_slack_nxt) > ALMFULL_SLACK))
            w_fired[CODE_ALMFULL_OVR] = 1'b1;
    end

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_state     <= ST_IDLE;
            r_slack_cnt <= 4'd0;
            r_err_valid <= 1'b0;
            r_err_code  <= 3'd0;
            r_err_addr  <= '0;
            r_err_mask  <= 8'd0;
            r_err_count <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_slack_cnt <= w_slack_nxt;
            r_err_valid <= |w_fired;
            r_err_mask  <= r_err_mask | w_fired;
            r_pkt_done  <= w_done;
            if (|w_fired) begin
                r_err_code  <= pick_code(w_fired);
                r_err_addr  <= C1TxAddr;
                r_err_count <= errcnt_inc(r_err_count);
            end
        end
    end

    // Packet context is only meaningful while r_state is PKT, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_open) begin
            r_base_addr  <= C1TxAddr;
            r_pkt_len    <= C1TxLen;
            r_pkt_vc     <= C1TxVc;
            r_beat_idx   <= 2'd1;
            r_beats_left <= C1TxLen;
        end else if (w_advance) begin
            r_beat_idx   <= r_beat_idx + 2'd1;
            r_beats_left <= r_beats_left - 2'd1;
        end
    end

    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign err_addr  = r_err_addr;
    assign err_mask  = r_err_mask;
    assign err_count = r_err_count;
    assign pkt_done  = r_pkt_done;
    assign in_pkt    = (r_state == ST_PKT);

endmodule

// File: tb/tb_ccip_c1tx_pkt_checker.sv
// Bench for ccip_c1tx_pkt_checker: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based packet model.
module tb_ccip_c1tx_pkt_checker;

    localparam int AW    = 42;
    localparam int CW    = 6;
    localparam int SLACK = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v = 1'b0, sop = 1'b0, af = 1'b0;
    logic [1:0]    len = 2'd0, vc = 2'd0;
    logic [AW-1:0] addr = '0;
    logic          err_valid, pkt_done, in_pkt;
    logic [2:0]    err_code;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_mask;
    logic [CW-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ccip_c1tx_pkt_checker #(.ADDR_WIDTH(AW), .ERRCNT_WIDTH(CW), .ALMFULL_SLACK(SLACK)) dut (
        .clk(clk), .SoftReset_n(rst_n),
        .C1TxWrValid(v), .C1TxSop(sop), .C1TxLen(len), .C1TxVc(vc),
        .C1TxAddr(addr), .C1TxAlmFull(af),
        .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
        .err_mask(err_mask), .err_count(err_count), .pkt_done(pkt_done), .in_pkt(in_pkt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the capturing edge.
    task automatic drive(input logic iv, input logic isop, input logic [1:0] ilen,
                         input logic [1:0] ivc, input logic [AW-1:0] iaddr, input logic iaf);
        v = iv; sop = isop; len = ilen; vc = ivc; addr = iaddr; af = iaf;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " err_valid"}, 64'(err_valid), 64'd0);
        chk({tag, " err_code"},  64'(err_code),  64'd0);
        chk({tag, " err_addr"},  64'(err_addr),  64'd0);
        chk({tag, " err_mask"},  64'(err_mask),  64'd0);
        chk({tag, " err_count"}, 64'(err_count), 64'd0);
        chk({tag, " pkt_done"},  64'(pkt_done),  64'd0);
        chk({tag, " in_pkt"},    64'(in_pkt),    64'd0);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]    len;
        logic [1:0]    vc;
        logic [AW-1:0] addr;
    } beat_t;

    beat_t         m_q[$];
    int            m_af;
    logic [7:0]    m_mask;
    int            m_count;
    logic          m_ev, m_done;
    logic [2:0]    m_code;
    logic [AW-1:0] m_addr;

    task automatic model_reset();
        m_q.delete();
        m_af = 0; m_mask = 8'd0; m_count = 0;
        m_code = 3'd0; m_addr = '0;
    endtask

    task automatic model_beat(input logic iv, input logic isop, input logic [1:0] ilen,
                              input logic [1:0] ivc, input logic [AW-1:0] iaddr, input logic iaf);
        logic [7:0] f;
        f = 8'd0;
        m_done = 1'b0;
        if (!iaf) m_af = 0;
        else if (iv) m_af++;
        if (iv && iaf && m_af > SLACK) f[6] = 1'b1;
        if (iv) begin
            if (isop) begin
                if (m_q.size() != 0) begin
                    f[2] = 1'b1;
                    m_q.delete();
                end
                if (ilen == 2'd2) f[3] = 1'b1;
                else if ((iaddr % (ilen + 1)) != 0) f[4] = 1'b1;
                else if (ilen == 2'd0) m_done = 1'b1;
                else for (int k = 1; k <= int'(ilen); k++)
                    m_q.push_back('{len: ilen, vc: ivc, addr: iaddr + AW'(k)});
            end else if (m_q.size() == 0) begin
                f[1] = 1'b1;
            end else if (m_q[0].len == ilen && m_q[0].vc == ivc && m_q[0].addr == iaddr) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end else begin
                f[5] = 1'b1;
                m_q.delete();
            end
        end
        m_ev = |f;
        if (m_ev) begin
            if (f[6]) m_code = 3'd6;
            else for (int c = 5; c >= 1; c--) if (f[c]) m_code = 3'(c);
            m_addr = iaddr;
            if (m_count < (1 << CW) - 1) m_count++;
        end
        m_mask |= f;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          v, sop;
        logic [1:0]    len, vc;
        logic [AW-1:0] addr;
        logic          af;
        logic          ev;
        logic [2:0]    code;
        logic [AW-1:0] ea;
        logic          done, inp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic isop, input logic [1:0] ilen, input logic [1:0] ivc,
                       input logic [AW-1:0] iaddr, input logic ev, input logic [2:0] code,
                       input logic done, input logic inp);
        tbl.push_back('{v: iv, sop: isop, len: ilen, vc: ivc, addr: iaddr, af: 1'b0,
                        ev: ev, code: code, ea: iaddr, done: done, inp: inp});
    endtask

    initial begin
        int tally;
        logic [1:0]    rlen, rvc;
        logic [AW-1:0] raddr;
        logic          rv, rsop, raf;

        add(1, 1, 3, 0, 'h100, 0, 0, 0, 1);
        add(0, 0, 0, 0, 'h000, 0, 0, 0, 1);
        add(1, 0, 3, 0, 'h101, 0, 0, 0, 1);
        add(1, 0, 3, 0, 'h102, 0, 0, 0, 1);
        add(1, 0, 3, 0, 'h103, 0, 0, 1, 0);
        add(1, 1, 2, 0, 'h200, 1, 3, 0, 0);
        add(1, 1, 3, 0, 'h202, 1, 4, 0, 0);
        add(1, 0, 0, 0, 'h250, 1, 1, 0, 0);
        add(1, 1, 1, 0, 'h300, 0, 0, 0, 1);
        add(1, 0, 1, 0, 'h302, 1, 5, 0, 0);
        add(1, 1, 3, 1, 'h400, 0, 0, 0, 1);
        add(1, 0, 3, 1, 'h401, 0, 0, 0, 1);
        add(1, 1, 0, 0, 'h500, 1, 2, 1, 0);
        add(1, 1, 1, 2, 'h600, 0, 0, 0, 1);
        add(1, 0, 1, 3, 'h601, 1, 5, 0, 0);
        add(1, 1, 3, 0, 'h700, 0, 0, 0, 1);
        add(1, 1, 2, 0, 'h800, 1, 2, 0, 0);
        add(1, 1, 1, 0, 'h900, 0, 0, 0, 1);
        add(1, 1, 1, 0, 'hA00, 1, 2, 0, 1);
        add(1, 0, 1, 0, 'hA01, 0, 0, 1, 0);
        add(1, 1, 1, 0, 'hB01, 1, 4, 0, 0);
        add(1, 1, 3, 0, 'hC00, 0, 0, 0, 1);
        add(1, 0, 3, 0, 'hC02, 1, 5, 0, 0);
        add(1, 1, 3, 0, 'hD00, 0, 0, 0, 1);
        add(1, 0, 1, 0, 'hD01, 1, 5, 0, 0);

        // Reset state
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        tally = 0;
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].sop, tbl[i].len, tbl[i].vc, tbl[i].addr, tbl[i].af);
            if (tbl[i].ev) tally++;
            chk($sformatf("vec%0d err_valid", i), 64'(err_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d err_code", i), 64'(err_code), 64'(tbl[i].code));
                chk($sformatf("vec%0d err_addr", i), 64'(err_addr), 64'(tbl[i].ea));
            end
            chk($sformatf("vec%0d pkt_done", i), 64'(pkt_done), 64'(tbl[i].done));
            chk($sformatf("vec%0d in_pkt", i), 64'(in_pkt), 64'(tbl[i].inp));
            chk($sformatf("vec%0d err_count", i), 64'(err_count), 64'(tally));
            if (i == 6) chk("len_align err_mask", 64'(err_mask), 64'h18);
        end
        chk("table err_mask", 64'(err_mask), 64'h3E);

        // AlmFull overrun from a clean reset
        rst_n = 1'b0; #3; rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0, AW'(i * 64), 1);
            chk($sformatf("af beat%0d err_valid", i + 1), 64'(err_valid), 64'(i >= 8));
            if (i >= 8) chk($sformatf("af beat%0d err_code", i + 1), 64'(err_code), 64'd6);
            chk($sformatf("af beat%0d pkt_done", i + 1), 64'(pkt_done), 64'd1);
        end
        chk("af err_count", 64'(err_count), 64'd2);
        chk("af err_mask", 64'(err_mask), 64'h40);
        drive(0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 0, AW'(i * 64), 1);
            chk($sformatf("af refill beat%0d err_valid", i + 1), 64'(err_valid), 64'd0);
        end
        chk("af refill err_count", 64'(err_count), 64'd2);

        // Asynchronous reset between beats 2 and 3 of a 4CL packet
        drive(1, 1, 3, 0, 'h100, 0);
        drive(1, 0, 3, 0, 'h101, 0);
        chk("pre-reset in_pkt", 64'(in_pkt), 64'd1);
        v = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midpkt reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 3, 0, 'h102, 0);
        chk("post-reset err_valid", 64'(err_valid), 64'd1);
        chk("post-reset err_code", 64'(err_code), 64'd1);
        chk("post-reset err_addr", 64'(err_addr), 64'h102);
        chk("post-reset in_pkt", 64'(in_pkt), 64'd0);
        chk("post-reset pkt_done", 64'(pkt_done), 64'd0);
        chk("post-reset err_count", 64'(err_count), 64'd1);

        // Randomized traffic against the model
        v = 1'b0; af = 1'b0;
        rst_n = 1'b0; #3; rst_n = 1'b1;
        model_reset();
        raf = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom % 16 == 0) raf = ~raf;
            rv = ($urandom % 5) != 0;
            if (m_q.size() != 0 && ($urandom % 4) != 0) begin
                rsop = 1'b0; rlen = m_q[0].len; rvc = m_q[0].vc; raddr = m_q[0].addr;
            end else begin
                rsop  = ($urandom % 4) != 0;
                rlen  = 2'($urandom % 4);
                rvc   = 2'($urandom % 4);
                raddr = AW'(($urandom % 16) * 4);
                if ($urandom % 3 == 0) raddr = raddr + AW'($urandom % 4);
            end
            model_beat(rv, rsop, rlen, rvc, raddr, raf);
            drive(rv, rsop, rlen, rvc, raddr, raf);
            chk($sformatf("rnd%0d err_valid", n), 64'(err_valid), 64'(m_ev));
            if (m_ev) begin
                chk($sformatf("rnd%0d err_code", n), 64'(err_code), 64'(m_code));
                chk($sformatf("rnd%0d err_addr", n), 64'(err_addr), 64'(m_addr));
            end
            chk($sformatf("rnd%0d pkt_done", n), 64'(pkt_done), 64'(m_done));
            chk($sformatf("rnd%0d in_pkt", n), 64'(in_pkt), 64'(m_q.size() != 0));
            chk($sformatf("rnd%0d err_mask", n), 64'(err_mask), 64'(m_mask));
            chk($sformatf("rnd%0d err_count", n), 64'(err_count), 64'(m_count));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
